// File: rtl/mos6502_bus_pkg.sv
// ----------------------------------------------------------------------------
// mos6502_bus_pkg
// Shared types for the 6502-style bus master: the bus-cycle state encoding,
// the queued request record and the CPU reset vector address.
// ----------------------------------------------------------------------------
package mos6502_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } bus_state_t;

    typedef struct packed {
        logic        write;
        logic        fetch;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } bus_req_t;

    localparam logic [15:0] RESET_VEC = 16'hFFFC;

endpackage : mos6502_bus_pkg

// File: rtl/mos6502_phi_gen.sv
// ----------------------------------------------------------------------------
// mos6502_phi_gen
// Free-running two-phase clock generator. PHI_1 is high for PHASE_CLKS clk,
// then PHI_2 is high for PHASE_CLKS clk; after reset the sequence restarts at
// the beginning of PHI_1.
//
// Ports:
//   clk_i         system clock
//   rst_ni        asynchronous active-low reset
//   phi1_o        PHI_1 phase clock
//   phi2_o        PHI_2 phase clock (complement of phi1_o)
//   phi1_start_o  high in the clk whose closing edge raises PHI_1
//   phi2_last_o   high in the last clk of PHI_2 (read-sample point)
// ----------------------------------------------------------------------------
module mos6502_phi_gen #(
    parameter int PHASE_CLKS = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic phi1_o,
    output logic phi2_o,
    output logic phi1_start_o,
    output logic phi2_last_o
);

    localparam logic [3:0] LAST_CNT = 4'(PHASE_CLKS - 1);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       phase_q;   // 0: PHI_1 high, 1: PHI_2 high
    logic       phase_d;
    logic       last_s;

    assign last_s = (cnt_q == LAST_CNT);

    // Phase counter next state: wrap and flip phase after PHASE_CLKS clk.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (last_s) begin
            cnt_d   = 4'd0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + 4'd1;
        end
    end

    // Phase counter state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= 4'd0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phi1_o       = ~phase_q;
    assign phi2_o       = phase_q;
    // The edge that ends PHI_2 is the same edge that starts PHI_1.
    assign phi2_last_o  = phase_q & last_s;
    assign phi1_start_o = phase_q & last_s;

endmodule : mos6502_phi_gen

// File: rtl/mos6502_bus_master.sv
// ----------------------------------------------------------------------------
// mos6502_bus_master
// 6502-style two-phase bus initiator for non-CPU agents. Requests enter a
// 2-entry queue (valid/ready); each queued request becomes one bus cycle
// starting at a PHI_1 rise, and completion is reported by a one-clk rsp_valid
// pulse in the clk right after PHI_2 falls.
//
// Ports:
//   clk, nRES                 clock, asynchronous active-low reset
//   req_valid/req_ready       request handshake
//   req_write/fetch/addr/wdata request contents
//   rsp_valid, rsp_rdata      completion pulse and read data (00 for writes)
//   Address_bus, RnW, SYNC    bus address/control, held for a whole cycle
//   Data_bus                  bidirectional data, driven only in write PHI_2
//   PHI_1, PHI_2              phase clocks
//   READY                     responder wait request
//
// Build option: define MOS6502_BUS_MASTER_RDY_EN to honour READY on reads
// (READY=0 at the read sample point repeats the same read cycle).
// ----------------------------------------------------------------------------
module mos6502_bus_master
    import mos6502_bus_pkg::*;
#(
    parameter int PHASE_CLKS  = 2,
    parameter int QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        nRES,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_fetch,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic [15:0] Address_bus,
    inout  wire  [7:0]  Data_bus,
    output logic        RnW,
    output logic        SYNC,
    output logic        PHI_1,
    output logic        PHI_2,
    input  logic        READY
);

    logic phi1_s, phi2_s, phi1_start_s, phi2_last_s;

    mos6502_phi_gen #(.PHASE_CLKS(PHASE_CLKS)) u_phi_gen (
        .clk_i        (clk),
        .rst_ni       (nRES),
        .phi1_o       (phi1_s),
        .phi2_o       (phi2_s),
        .phi1_start_o (phi1_start_s),
        .phi2_last_o  (phi2_last_s)
    );

    // ---------------- request queue ----------------
    bus_req_t   q_mem_q [2];
    logic       q_wr_ptr_q, q_rd_ptr_q;
    logic [1:0] q_count_q, q_count_d;
    logic       req_ready_q;
    logic       push_s, pop_s;
    bus_req_t   req_s, head_s;

    assign req_s     = '{write: req_write, fetch: req_fetch, addr: req_addr, wdata: req_wdata};
    assign head_s    = q_mem_q[q_rd_ptr_q];
    assign push_s    = req_valid & req_ready_q;
    assign q_count_d = q_count_q + {1'b0, push_s} - {1'b0, pop_s};

    // Queue storage, pointers, occupancy and registered ready.
    always_ff @(posedge clk or negedge nRES) begin
        if (!nRES) begin
            q_mem_q[0]  <= '0;
            q_mem_q[1]  <= '0;
            q_wr_ptr_q  <= 1'b0;
            q_rd_ptr_q  <= 1'b0;
            q_count_q   <= 2'd0;
            req_ready_q <= 1'b0;
        end else begin
            if (push_s) begin
                q_mem_q[q_wr_ptr_q] <= req_s;
                q_wr_ptr_q          <= ~q_wr_ptr_q;
            end
            if (pop_s) begin
                q_rd_ptr_q <= ~q_rd_ptr_q;
            end
            q_count_q   <= q_count_d;
            // Registered from next occupancy: a full queue popped this clk
            // still shows not-ready until the following clk.
            req_ready_q <= (q_count_d != 2'(QUEUE_DEPTH));
        end
    end

    assign req_ready = req_ready_q;

    // ---------------- READY qualification ----------------
    logic ready_ok_s;
`ifdef MOS6502_BUS_MASTER_RDY_EN
    assign ready_ok_s = READY;
`else
    // READY is a don't-care in this build; every cycle completes.
    assign ready_ok_s = READY | 1'b1;
`endif

    // ---------------- bus cycle FSM ----------------
    bus_state_t  state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic        rnw_q, rnw_d;
    logic        sync_q, sync_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic        retry_s;

    // A read held off by READY keeps its state and is re-run unchanged.
    assign retry_s = (state_q == READ) & ~ready_ok_s;

    // Next state: complete the current cycle at the PHI_2 end, then pick the
    // next cycle (queue head or idle) for the PHI_1 rise on the same edge.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rnw_d       = rnw_q;
        sync_d      = sync_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        pop_s       = 1'b0;

        if (phi2_last_s && !retry_s) begin
            case (state_q)
                READ: begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = Data_bus;
                end
                WRITE: begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = 8'h00;
                end
                default: begin
                    rsp_valid_d = 1'b0;
                end
            endcase
        end else begin
            rsp_valid_d = 1'b0;
        end

        if (phi1_start_s && !retry_s) begin
            if (q_count_q != 2'd0) begin
                pop_s   = 1'b1;
                state_d = head_s.write ? WRITE : READ;
                addr_d  = head_s.addr;
                rnw_d   = ~head_s.write;
                sync_d  = ~head_s.write & head_s.fetch;
                wdata_d = head_s.wdata;
            end else begin
                state_d = IDLE;
                rnw_d   = 1'b1;
                sync_d  = 1'b0;
            end
        end else begin
            pop_s = 1'b0;
        end
    end

    // FSM and bus output registers.
    always_ff @(posedge clk or negedge nRES) begin
        if (!nRES) begin
            state_q     <= IDLE;
            addr_q      <= 16'h0000;
            rnw_q       <= 1'b1;
            sync_q      <= 1'b0;
            wdata_q     <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rnw_q       <= rnw_d;
            sync_q      <= sync_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign Data_bus    = (phi2_s && !rnw_q) ? wdata_q : 8'hzz;
    assign Address_bus = addr_q;
    assign RnW         = rnw_q;
    assign SYNC        = sync_q;
    assign PHI_1       = phi1_s;
    assign PHI_2       = phi2_s;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;

endmodule : mos6502_bus_master

// File: doc/mos6502_bus_master.md
# mos6502_bus_master

Synthesizable initiator for the 6502-style two-phase bus: it generates PHI_1/PHI_2, drives Address_bus, RnW, SYNC and write data, and samples read data, exactly as the MOS_6502 core does toward memory. It sits beside memory and peripherals so that non-CPU agents (image loader, debug port, DMA) can run legal bus cycles against the same memory responder the CPU uses. Requests enter through a 2-deep queue with a valid/ready handshake. Completions return as a one-clock response pulse.

## Interface
- PHASE_CLKS, 2: clk cycles per bus phase; legal range 1..15; one bus cycle = 2*PHASE_CLKS clk.
- QUEUE_DEPTH, 2: request queue entries; fixed at 2 for this revision.
- clk  in  1  system clock; one clock domain.
- nRES  in  1  asynchronous, active-low reset.
- req_valid  in  1  request offered.
- req_ready  out  1  queue can accept; a request transfers when req_valid & req_ready at posedge clk.
- req_write  in  1  1 = write cycle, 0 = read cycle.
- req_fetch  in  1  read is an opcode fetch; drives SYNC for that cycle; ignored on writes.
- req_addr  in  16  bus address.
- req_wdata  in  8  write data.
- rsp_valid  out  1  one-clk pulse per completed bus cycle.
- rsp_rdata  out  8  sampled read data; 8'h00 for writes.
- Address_bus  out  16  bus address.
- Data_bus  inout  8  driven only when PHI_2 & ~RnW; high-Z otherwise.
- RnW  out  1  1 = read.
- SYNC  out  1  high for the whole opcode-fetch cycle.
- PHI_1, PHI_2  out  1  non-overlapping phase clocks, complementary.
- READY  in  1  responder wait request (RDY semantics).

## Operation
- Reset values: PHI_1=1, PHI_2=0, RnW=1, SYNC=0, Address_bus=16'h0000, Data_bus high-Z, rsp_valid=0, rsp_rdata=8'h00, req_ready=0. The queue is emptied and the phase counter cleared.
- req_ready rises on the first clk after nRES deasserts. Afterwards req_ready = queue not full.
- Phase generator runs freely. PHI_1 is high for PHASE_CLKS clk, then PHI_2 is high for PHASE_CLKS clk.
- FSM states:
  - IDLE: idle cycle; RnW=1, SYNC=0, address held from the last cycle, no response.
  - READ.
  - WRITE.
- The state is chosen only at each PHI_1 rise. If the queue is non-empty, the head is popped and becomes READ or WRITE. Otherwise the state is IDLE.
- Address_bus, RnW and SYNC are updated at the PHI_1 rise and held for the full cycle.
- WRITE: Data_bus = wdata while PHI_2 is high.
- READ: Data_bus is sampled on the last clk of PHI_2.
- A request accepted during a bus cycle issues no earlier than the next PHI_1 rise.
- A push and a pop on the same clk are both honoured. A full queue with a simultaneous pop still reports req_ready=0 that clk.
- Reset mid-cycle aborts the cycle immediately. No response is generated for the aborted cycle.

## Timing
- Phase boundaries fall on clk posedge, counted from the reset release.
- Minimum request-to-PHI_1 latency: 1 clk.
- rsp_valid pulses on the clk immediately after PHI_2 falls, for 1 clk. rsp_rdata is valid in that same clk and is held until the next response.
- Back-to-back queued requests give one response every 2*PHASE_CLKS clk.

## Configuration
- MOS6502_BUS_MASTER_RDY_EN defined:
  - READY is sampled with the read data on the last clk of PHI_2.
  - READY=0 on a READ discards the sample and repeats the same read cycle (same address, same SYNC). No response is generated, and the queue is not popped.
  - Writes ignore READY.
- Undefined: READY is ignored, and every cycle completes in exactly 2*PHASE_CLKS clk.

## Structure
- Shared package mos6502_bus_pkg:
  - bus_state_t enum {IDLE, READ, WRITE}.
  - bus_req_t struct {write, fetch, addr[15:0], wdata[7:0]}.
  - localparam RESET_VEC=16'hFFFC.
- Sub-module mos6502_phi_gen: PHASE_CLKS counter. Outputs PHI_1, PHI_2, and the strobes phi1_start and phi2_last.
- Queue, FSM and bus drivers stay in the top level.

## Test plan
- Reset held 5 clk: all outputs at their reset values, Data_bus high-Z. req_ready=1 on the first clk after release.
- Write 8'hA5 to 16'h0200, then read 16'h0200, with PHASE_CLKS=2: Data_bus=A5 only during the write's PHI_2. The read returns rsp_rdata=8'hA5. The two responses are 4 clk apart.
- Read with req_fetch=1 at 16'hFFFC: SYNC=1 for all 4 clk of that cycle and 0 in the following idle cycle.
- Three requests pushed on consecutive clk: the third sees req_ready=0 until the first pops at PHI_1. The cycles are issued in order with no idle cycle between them.
- With RDY_EN defined, READY=0 for 2 read cycles at 16'h1234: address repeats 3 times, with a single rsp_valid after the third cycle. A write with READY=0 still completes in 4 clk.
- nRES asserted in the middle of a write's PHI_2: Data_bus goes high-Z immediately, no rsp_valid, and the queue is empty after release.
